// File: rtl/otter_hazard_unit.sv
// otter_hazard_unit: scoreboard-based forwarding and load-use stall control.
// Optional perf counters (STALL_CNT/FLUSH_CNT) when OTTER_HZD_PERF_CNT_EN is defined.
module otter_hazard_unit #(
  parameter int NUM_STAGES     = 3,
  parameter int NUM_RD_PORTS   = 2,
  parameter int LOAD_READY_STG = 2,
  localparam int SELW = $clog2(NUM_STAGES + 1)
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           HOLD,
  input  logic                           FLUSH,
  input  logic                           DEC_VALID,
  input  logic [5*NUM_RD_PORTS-1:0]      DEC_RS,
  input  logic [NUM_RD_PORTS-1:0]        DEC_RS_USED,
  input  logic [4:0]                     DEC_RD,
  input  logic                           DEC_RD_WE,
  input  logic                           DEC_IS_LOAD,
  output logic                           STALL,
  output logic                           BUBBLE,
  output logic [SELW*NUM_RD_PORTS-1:0]   FWD_SEL
`ifdef OTTER_HZD_PERF_CNT_EN
  ,
  output logic [31:0]                    STALL_CNT,
  output logic [31:0]                    FLUSH_CNT
`endif
);

  logic       vld_q [1:NUM_STAGES];
  logic       vld_d [1:NUM_STAGES];
  logic       ld_q  [1:NUM_STAGES];
  logic       ld_d  [1:NUM_STAGES];
  logic [4:0] rd_q  [1:NUM_STAGES];
  logic [4:0] rd_d  [1:NUM_STAGES];

  logic [SELW-1:0] sel_p [NUM_RD_PORTS];
  logic [4:0]      rs_p  [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] haz_p;
  logic            haz;

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    haz_p   = '0;
    FWD_SEL = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      sel_p[p] = '0;
      rs_p[p]  = DEC_RS[5*p +: 5];
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (DEC_VALID && DEC_RS_USED[p] && vld_q[k] &&
            rd_q[k] == rs_p[p] && rs_p[p] != 5'd0) begin
          sel_p[p] = SELW'(k);
          haz_p[p] = ld_q[k] & (k < LOAD_READY_STG);
        end
      end
      if (RST_N) begin
        FWD_SEL[SELW*p +: SELW] = sel_p[p];
      end
    end
  end

  assign haz    = |haz_p;
  assign STALL  = haz & ~FLUSH & RST_N;
  assign BUBBLE = (STALL | FLUSH) & RST_N;

  always_comb begin
    vld_d = vld_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    if (!HOLD) begin
      for (int k = NUM_STAGES; k >= 2; k--) begin
        vld_d[k] = vld_q[k-1];
        ld_d[k]  = ld_q[k-1];
        rd_d[k]  = rd_q[k-1];
      end
      vld_d[1] = DEC_VALID & DEC_RD_WE & (DEC_RD != 5'd0) & ~STALL & ~FLUSH;
      rd_d[1]  = DEC_RD;
      ld_d[1]  = DEC_IS_LOAD;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        vld_q[k] <= 1'b0;
        ld_q[k]  <= 1'b0;
        rd_q[k]  <= 5'd0;
      end
    end else begin
      vld_q <= vld_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
    end
  end

`ifdef OTTER_HZD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!HOLD && STALL && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!HOLD && FLUSH && flush_cnt_q != 32'hFFFF_FFFF) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Bench for otter_hazard_unit: default instance (3 stages) and a deep one
// (5 stages, load ready at 4) share stimulus; a history-queue model predicts both.
module tb_otter_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, hold, flush, dv, we, ld;
  logic [9:0] rs;
  logic [1:0] used;
  logic [4:0] rd;
  logic       st0, bb0, st1, bb1;
  logic [3:0] fwd0;
  logic [5:0] fwd1;
`ifdef OTTER_HZD_PERF_CNT_EN
  logic [31:0] sc0, fc0, sc1, fc1;
`endif

  int checks = 0;
  int errors = 0;

  otter_hazard_unit u_dut0 (
    .CLK(clk), .RST_N(rst_n), .HOLD(hold), .FLUSH(flush),
    .DEC_VALID(dv), .DEC_RS(rs), .DEC_RS_USED(used),
    .DEC_RD(rd), .DEC_RD_WE(we), .DEC_IS_LOAD(ld),
    .STALL(st0), .BUBBLE(bb0), .FWD_SEL(fwd0)
`ifdef OTTER_HZD_PERF_CNT_EN
    , .STALL_CNT(sc0), .FLUSH_CNT(fc0)
`endif
  );

  otter_hazard_unit #(
    .NUM_STAGES(5), .NUM_RD_PORTS(2), .LOAD_READY_STG(4)
  ) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .HOLD(hold), .FLUSH(flush),
    .DEC_VALID(dv), .DEC_RS(rs), .DEC_RS_USED(used),
    .DEC_RD(rd), .DEC_RD_WE(we), .DEC_IS_LOAD(ld),
    .STALL(st1), .BUBBLE(bb1), .FWD_SEL(fwd1)
`ifdef OTTER_HZD_PERF_CNT_EN
    , .STALL_CNT(sc1), .FLUSH_CNT(fc1)
`endif
  );

  // History of issued writes, newest at index 0 (age 1).
  typedef struct packed {bit v; bit [4:0] rd; bit ld;} ent_t;
  ent_t hq0[$];
  ent_t hq1[$];
  bit [31:0] mscnt [2];
  bit [31:0] mfcnt [2];

  function automatic int qsize(input int i);
    return (i == 0) ? hq0.size() : hq1.size();
  endfunction

  function automatic ent_t qget(input int i, input int idx);
    return (i == 0) ? hq0[idx] : hq1[idx];
  endfunction

  function automatic void clear_model();
    hq0.delete();
    hq1.delete();
    mscnt[0] = 0; mscnt[1] = 0;
    mfcnt[0] = 0; mfcnt[1] = 0;
  endfunction

  function automatic void eval(input int i, output bit st, output bit bb,
                               output int s0, output int s1);
    int dep, lrs;
    int sel[2];
    bit haz;
    ent_t e;
    dep = (i == 0) ? 3 : 5;
    lrs = (i == 0) ? 2 : 4;
    haz = 0;
    for (int p = 0; p < 2; p++) begin
      sel[p] = 0;
      if (dv && used[p] && rs[5*p +: 5] != 5'd0) begin
        for (int k = 1; k <= dep; k++) begin
          if (sel[p] == 0 && k <= qsize(i)) begin
            e = qget(i, k - 1);
            if (e.v && e.rd == rs[5*p +: 5]) begin
              sel[p] = k;
              if (e.ld && k < lrs) haz = 1;
            end
          end
        end
      end
    end
    st = haz && !flush && rst_n;
    bb = (st || flush) && rst_n;
    s0 = rst_n ? sel[0] : 0;
    s1 = rst_n ? sel[1] : 0;
  endfunction

  task automatic tick();
    bit st[2];
    bit bb;
    int a, b;
    ent_t e;
    for (int i = 0; i < 2; i++) eval(i, st[i], bb, a, b);
    @(posedge clk);
    if (rst_n && !hold) begin
      for (int i = 0; i < 2; i++) begin
        e.v  = dv && we && rd != 5'd0 && !st[i] && !flush;
        e.rd = rd;
        e.ld = ld;
        if (i == 0) begin
          hq0.push_front(e);
          if (hq0.size() > 3) void'(hq0.pop_back());
        end else begin
          hq1.push_front(e);
          if (hq1.size() > 5) void'(hq1.pop_back());
        end
        if (st[i] && mscnt[i] != 32'hFFFF_FFFF) mscnt[i]++;
        if (flush && mfcnt[i] != 32'hFFFF_FFFF) mfcnt[i]++;
      end
    end
    if (!rst_n) clear_model();
    #1;
  endtask

  task automatic set_in(input bit v, input bit [4:0] r0, input bit u0,
                        input bit [4:0] r1, input bit u1, input bit [4:0] d,
                        input bit w, input bit l, input bit fl, input bit h);
    dv = v; rs = {r1, r0}; used = {u1, u0};
    rd = d; we = w; ld = l; flush = fl; hold = h;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    set_in(1, 1, 1, 2, 1, 3, 1, 0, 1, 0);
    checks++;
    if ({st0, bb0, fwd0} !== 6'b0) begin
      errors++; $display("FAIL reset_dut0 got %b want 000000", {st0, bb0, fwd0});
    end
    checks++;
    if ({st1, bb1, fwd1} !== 8'b0) begin
      errors++; $display("FAIL reset_dut1 got %b want 00000000", {st1, bb1, fwd1});
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_empty_pipe();
    set_in(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
    checks++;
    if ({st0, bb0, fwd0} !== 6'b0) begin
      errors++; $display("FAIL empty_pipe got %b want 000000", {st0, bb0, fwd0});
    end
    tick();
  endtask

  task automatic test_fwd_ex();
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    set_in(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    checks++;
    if ({st0, bb0, fwd0} !== 6'b00_0101) begin
      errors++; $display("FAIL fwd_ex got %b want 000101", {st0, bb0, fwd0});
    end
    tick();
  endtask

  task automatic test_load_use();
    set_in(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
    tick();
    set_in(1, 7, 1, 0, 1, 8, 1, 0, 0, 0);
    checks++;
    if ({st0, bb0} !== 2'b11) begin
      errors++; $display("FAIL load_use_stall got %b want 11", {st0, bb0});
    end
    tick();
    #1;
    checks++;
    if ({st0, bb0, fwd0} !== 6'b00_0010) begin
      errors++; $display("FAIL load_use_fwd got %b want 000010", {st0, bb0, fwd0});
    end
    tick();
  endtask

  task automatic test_youngest();
    set_in(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);  tick();
    set_in(1, 0, 0, 0, 0, 10, 1, 0, 0, 0); tick();
    set_in(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);  tick();
    set_in(1, 9, 1, 9, 1, 0, 0, 0, 0, 0);
    checks++;
    if (fwd0 !== 4'b0101) begin
      errors++; $display("FAIL youngest got %b want 0101", fwd0);
    end
    tick();
    set_in(1, 0, 0, 0, 0, 12, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  tick();
    tick();
    set_in(1, 12, 0, 12, 1, 0, 0, 0, 0, 0);
    checks++;
    if (fwd0 !== 4'b1100) begin
      errors++; $display("FAIL wb_fwd got %b want 1100", fwd0);
    end
    tick();
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_in(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (fwd0 !== 4'b0000) begin
      errors++; $display("FAIL x0_fwd got %b want 0000", fwd0);
    end
    tick();
  endtask

  task automatic test_flush();
    set_in(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
    tick();
    set_in(1, 7, 1, 0, 0, 8, 1, 0, 1, 0);
    checks++;
    if ({st0, bb0} !== 2'b01) begin
      errors++; $display("FAIL flush_wins got %b want 01", {st0, bb0});
    end
    tick();
    set_in(1, 8, 1, 7, 1, 13, 0, 0, 0, 0);
    checks++;
    if ({st0, bb0, fwd0} !== 6'b00_1000) begin
      errors++; $display("FAIL flush_entry got %b want 001000", {st0, bb0, fwd0});
    end
    tick();
  endtask

  task automatic test_hold();
    set_in(1, 0, 0, 0, 0, 11, 1, 0, 0, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      set_in(1, 11, 1, 0, 0, 14, 1, 0, 0, 1);
      checks++;
      if ({bb0, fwd0[1:0]} !== 3'b001) begin
        errors++; $display("FAIL hold_fwd got %b want 001", {bb0, fwd0[1:0]});
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (fwd0[1:0] !== 2'd2) begin
      errors++; $display("FAIL hold_frozen got %0d want 2", fwd0[1:0]);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_in(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
    tick();
    set_in(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    checks++;
    if (st0 !== 1'b1) begin
      errors++; $display("FAIL pre_reset_stall got %b want 1", st0);
    end
    rst_n = 1'b0;
    clear_model();
    #1;
    checks++;
    if ({st0, bb0, st1, bb1} !== 4'b0) begin
      errors++; $display("FAIL reset_mid_stall got %b want 0000", {st0, bb0, st1, bb1});
    end
    tick();
    rst_n = 1'b1;
    set_in(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    checks++;
    if ({st0, bb0, fwd0} !== 6'b0) begin
      errors++; $display("FAIL after_reset got %b want 000000", {st0, bb0, fwd0});
    end
    tick();
  endtask

  task automatic test_deep();
    int n;
    do_reset();
    set_in(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
    tick();
    set_in(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (st1 !== 1'b1) break;
      n++;
      tick();
      #1;
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL deep_stall_len got %0d want 3", n);
    end
    checks++;
    if ({st1, fwd1[2:0]} !== 4'b0100) begin
      errors++; $display("FAIL deep_fwd got %b want 0100", {st1, fwd1[2:0]});
    end
    tick();
  endtask

  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
      tick();
      if (i == 0) begin
        set_in(1, 7, 1, 0, 0, 8, 1, 0, 0, 1);
        tick();
      end
      set_in(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
      tick();
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef OTTER_HZD_PERF_CNT_EN
    checks++;
    if (sc0 !== 32'd3 || fc0 !== 32'd2) begin
      errors++; $display("FAIL counters got %0d/%0d want 3/2", sc0, fc0);
    end
    checks++;
    if (sc1 !== mscnt[1] || fc1 !== mfcnt[1]) begin
      errors++; $display("FAIL counters_deep got %0d/%0d want %0d/%0d",
                         sc1, fc1, mscnt[1], mfcnt[1]);
    end
`endif
  endtask

  task automatic test_random();
    bit est, ebb;
    int a, b;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      hold  = ($urandom % 8) == 0;
      flush = ($urandom % 8) == 0;
      dv    = ($urandom % 4) != 0;
      rs    = {5'($urandom % 4), 5'($urandom % 4)};
      used  = 2'($urandom);
      rd    = 5'($urandom % 4);
      we    = ($urandom % 4) != 0;
      ld    = ($urandom % 3) == 0;
      #1;
      eval(0, est, ebb, a, b);
      checks++;
      if ({st0, bb0, fwd0} !== {est, ebb, 2'(b), 2'(a)}) begin
        errors++; $display("FAIL rand_dut0 cyc %0d got %b want %b", c,
                           {st0, bb0, fwd0}, {est, ebb, 2'(b), 2'(a)});
      end
      eval(1, est, ebb, a, b);
      checks++;
      if ({st1, bb1, fwd1} !== {est, ebb, 3'(b), 3'(a)}) begin
        errors++; $display("FAIL rand_dut1 cyc %0d got %b want %b", c,
                           {st1, bb1, fwd1}, {est, ebb, 3'(b), 3'(a)});
      end
      tick();
    end
`ifdef OTTER_HZD_PERF_CNT_EN
    checks++;
    if (sc0 !== mscnt[0] || fc0 !== mfcnt[0]) begin
      errors++; $display("FAIL rand_counters got %0d/%0d want %0d/%0d",
                         sc0, fc0, mscnt[0], mfcnt[0]);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    clear_model();
    test_reset();
    test_empty_pipe();
    test_fwd_ex();
    test_load_use();
    test_youngest();
    test_flush();
    test_hold();
    test_reset_mid_stall();
    test_deep();
    test_counters();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
